tdm_demux_4ch: RTL and testbench
================================

# tdm_demux_4ch

Four-channel time-division demultiplexer: the receive end of the team's 4:1 select-line mux path. It takes a serialized word stream in which a frame-sync flag marks channel 0, and steers each word into one of four registered channel outputs. It tracks frame alignment with a two-state lock machine, flags alignment faults, and re-acquires sync automatically. It sits between the serial link and the per-channel consumers.

## Interface
Parameters:
- W, 8, data word width in bits (≥1)

Ports (single clock; reset is synchronous and active-high):
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous active-high reset
- din  input  W  serialized channel word
- din_valid  input  1  din is a valid word this cycle
- frame_sync  input  1  qualifies din as channel 0 of a new frame; ignored unless din_valid
- ch0_out, ch1_out, ch2_out, ch3_out  output  W each  last word delivered to channel n (held until overwritten)
- ch_strobe  output  4  one-hot, one-cycle pulse: bit n = chn_out updated this cycle
- frame_done  output  1  one-cycle pulse: a complete, in-order frame (ch0..ch3) has been delivered
- locked  output  1  high while in LOCKED state
- sync_err  output  1  one-cycle pulse on an alignment fault

## Operation
- State machine: HUNT, LOCKED. Channel counter `cnt` is 2 bits.
- Reset: state=HUNT, cnt=0, all chn_out=0, ch_strobe=0, frame_done=0, locked=0, sync_err=0.
- Cycles with din_valid=0: no state, counter, or output-data change. Strobes and pulses are 0.
- HUNT:
  - valid word with frame_sync=0: discarded. No strobe, no error.
  - valid word with frame_sync=1: write ch0_out, pulse ch_strobe[0], set cnt=1, go to LOCKED.
- LOCKED, valid word:
  - frame_sync=0, cnt≠0: write ch[cnt]_out, pulse ch_strobe[cnt], cnt=cnt+1 (wraps 3→0).
  - frame_sync=0, cnt=3: the write is as above. frame_done pulses with it.
  - frame_sync=1, cnt=0: normal frame start. Write ch0, cnt=1.
  - frame_sync=1, cnt≠0 (early sync): pulse sync_err, realign. The word goes to ch0_out with ch_strobe[0], and cnt=1. Stay LOCKED. No frame_done for the truncated frame.
  - frame_sync=0, cnt=0 (missing sync): pulse sync_err, discard the word, go to HUNT.
- frame_done fires only when all four words of the frame were delivered consecutively in LOCKED after a ch0 with frame_sync.
- A reset asserted mid-frame overrides everything. It returns the block to the reset values on the next edge, and the partial frame is lost.

## Timing
- Latency is 1 cycle from the din_valid edge to the chn_out/ch_strobe update. All outputs are registered.
- frame_done is asserted in the same cycle as ch_strobe[3].
- sync_err is asserted in the cycle after the offending word is sampled.
- locked rises in the cycle after the first accepted frame_sync (coincident with ch_strobe[0]). It falls in the cycle after the missing-sync word (coincident with sync_err).
- Throughput is one word per cycle with no bubbles required. Back-to-back frames sustain frame_done every 4 valid cycles.
- There is no backpressure: the consumer must accept every strobe.

## Structure
- Shared package `tdm_pkg` holds:
  - NUM_CH=4
  - CNT_W=2
  - state enum {HUNT, LOCKED}
- A future mux-side transmitter reuses the same package.
- One sub-module, `tdm_sync_fsm`, contains the state register, cnt, locked, sync_err and frame_done logic. It exports `sel` (cnt) and `wr_en`.
- The top level contains the W-bit channel registers and the strobe decode.

## Test plan
- Reset then clean frame: rst for 2 cycles, then valid words A1(sync), B2, C3, D4 back-to-back. Required response:
  - ch0..3_out = A1, B2, C3, D4.
  - ch_strobe = 0001, 0010, 0100, 1000 on consecutive cycles.
  - frame_done on the 4th; locked=1 from the 1st.
- Hunt discard: words 11, 22 (no sync), then 33(sync). Required response: no strobes for 11 and 22; ch0_out=33 and locked=1 one cycle after 33.
- Early sync: words 01(sync), 02, then 03(sync). Required response:
  - sync_err pulses.
  - ch0_out=03; ch1_out stays 02.
  - No frame_done; still locked.
- Missing sync: a full frame, then word 55 with frame_sync=0. Required response:
  - sync_err pulses; locked→0; no strobe.
  - ch outputs keep the previous frame's values.
- Gaps: frame words interleaved with din_valid=0 cycles. Required response: outputs identical to the clean-frame case, shifted only in time; no pulses on idle cycles.
- Reset mid-frame: rst during the cycle after word 2. Required response: all outputs return to 0 and locked=0; a subsequent sync frame delivers normally.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared definitions for the 4-channel TDM link (demux receiver and future mux transmitter).
//   NUM_CH    : channels per frame
//   CNT_W     : width of the channel counter / select
//   state_e   : frame-alignment state (HUNT, LOCKED)
//   ch_onehot : channel select to one-hot strobe vector
package tdm_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CNT_W  = 2;

  typedef enum logic {
    HUNT,
    LOCKED
  } state_e;

  function automatic logic [NUM_CH-1:0] ch_onehot(input logic [CNT_W-1:0] sel);
    logic [NUM_CH-1:0] vec;
    vec      = '0;
    vec[sel] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/tdm_sync_fsm.sv
// Frame-alignment tracker for the TDM demux.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   i_valid        : incoming word is valid this cycle
//   i_sync         : incoming word carries the frame-sync flag
//   o_wr_en        : write the current word into channel o_sel (combinational)
//   o_sel          : target channel of the current word (combinational)
//   o_locked       : registered, high while LOCKED
//   o_sync_err     : registered one-cycle pulse on an alignment fault
//   o_frame_done   : registered one-cycle pulse when ch3 of an in-order frame lands
module tdm_sync_fsm
  import tdm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic             i_sync,
  output logic             o_wr_en,
  output logic [CNT_W-1:0] o_sel,
  output logic             o_locked,
  output logic             o_sync_err,
  output logic             o_frame_done
);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_locked;
  logic             r_sync_err;
  logic             r_frame_done;

  logic             w_wr_en;
  logic [CNT_W-1:0] w_sel;

  localparam logic [CNT_W-1:0] LastCh = CNT_W'(NUM_CH - 1);

  // A sync word always lands in ch0; a plain word only lands mid-frame while locked.
  always_comb begin
    w_wr_en = 1'b0;
    w_sel   = '0;
    if (i_valid) begin
      unique case (r_state)
        HUNT: begin
          w_wr_en = i_sync;
        end
        LOCKED: begin
          if (i_sync) begin
            w_wr_en = 1'b1;
          end else if (r_cnt != '0) begin
            w_wr_en = 1'b1;
            w_sel   = r_cnt;
          end
        end
        default: begin
          w_wr_en = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= HUNT;
      r_cnt        <= '0;
      r_locked     <= 1'b0;
      r_sync_err   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_sync_err   <= 1'b0;
      r_frame_done <= 1'b0;
      if (i_valid) begin
        unique case (r_state)
          HUNT: begin
            if (i_sync) begin
              r_state  <= LOCKED;
              r_cnt    <= CNT_W'(1);
              r_locked <= 1'b1;
            end
          end
          LOCKED: begin
            if (i_sync) begin
              // Early sync realigns onto ch0 but flags the truncated frame.
              r_cnt <= CNT_W'(1);
              if (r_cnt != '0) begin
                r_sync_err <= 1'b1;
              end
            end else if (r_cnt == '0) begin
              // Expected a sync word here: alignment lost.
              r_sync_err <= 1'b1;
              r_state    <= HUNT;
              r_locked   <= 1'b0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
              if (r_cnt == LastCh) begin
                r_frame_done <= 1'b1;
              end
            end
          end
          default: begin
            r_state  <= HUNT;
            r_cnt    <= '0;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_wr_en      = w_wr_en;
  assign o_sel        = w_sel;
  assign o_locked     = r_locked;
  assign o_sync_err   = r_sync_err;
  assign o_frame_done = r_frame_done;

endmodule

// File: rtl/tdm_demux_4ch.sv
// Four-channel time-division demultiplexer.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   din, din_valid    : serialized word and its qualifier
//   frame_sync        : marks din as channel 0 of a new frame (only when din_valid)
//   ch0..ch3_out      : last word delivered to each channel, held until overwritten
//   ch_strobe         : one-hot pulse, bit n = chn_out updated this cycle
//   frame_done        : pulse when a complete in-order frame has been delivered
//   locked            : high while frame alignment is held
//   sync_err          : pulse on an alignment fault
module tdm_demux_4ch
  import tdm_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W-1:0]      din,
  input  logic              din_valid,
  input  logic              frame_sync,
  output logic [W-1:0]      ch0_out,
  output logic [W-1:0]      ch1_out,
  output logic [W-1:0]      ch2_out,
  output logic [W-1:0]      ch3_out,
  output logic [NUM_CH-1:0] ch_strobe,
  output logic              frame_done,
  output logic              locked,
  output logic              sync_err
);

  logic             w_wr_en;
  logic [CNT_W-1:0] w_sel;

  logic [W-1:0]      r_ch [NUM_CH];
  logic [NUM_CH-1:0] r_strobe;

  tdm_sync_fsm u_sync_fsm (
    .clk          (clk),
    .rst          (rst),
    .i_valid      (din_valid),
    .i_sync       (frame_sync),
    .o_wr_en      (w_wr_en),
    .o_sel        (w_sel),
    .o_locked     (locked),
    .o_sync_err   (sync_err),
    .o_frame_done (frame_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ch     <= '{default: '0};
      r_strobe <= '0;
    end else begin
      r_strobe <= '0;
      if (w_wr_en) begin
        r_ch[w_sel] <= din;
        r_strobe    <= ch_onehot(w_sel);
      end
    end
  end

  assign ch0_out   = r_ch[0];
  assign ch1_out   = r_ch[1];
  assign ch2_out   = r_ch[2];
  assign ch3_out   = r_ch[3];
  assign ch_strobe = r_strobe;

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Self-checking bench for tdm_demux_4ch: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a frame-position model.
module tb_tdm_demux_4ch;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         frame_sync = 1'b0;
  logic [W-1:0] ch0_out, ch1_out, ch2_out, ch3_out;
  logic [3:0]   ch_strobe;
  logic         frame_done, locked, sync_err;

  tdm_demux_4ch #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .ch0_out    (ch0_out),
    .ch1_out    (ch1_out),
    .ch2_out    (ch2_out),
    .ch3_out    (ch3_out),
    .ch_strobe  (ch_strobe),
    .frame_done (frame_done),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: aligned flag and number of words of the current frame already delivered (1..4).
  bit           m_aligned = 0;
  int           m_pos     = 0;
  logic [W-1:0] e_ch [4]  = '{default: '0};
  logic [3:0]   e_strobe  = '0;
  bit           e_done = 0, e_lock = 0, e_err = 0;
  bit           check_en  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model(input bit r, input bit v, input bit s, input logic [W-1:0] d);
    e_strobe = '0;
    e_done   = 0;
    e_err    = 0;
    if (r) begin
      m_aligned = 0;
      m_pos     = 0;
      e_ch      = '{default: '0};
    end else if (v) begin
      if (!m_aligned) begin
        if (s) begin
          m_aligned = 1;
          m_pos     = 1;
          e_ch[0]   = d;
          e_strobe  = 4'b0001;
        end
      end else if (s) begin
        if (m_pos != 4) e_err = 1;
        m_pos    = 1;
        e_ch[0]  = d;
        e_strobe = 4'b0001;
      end else if (m_pos == 4) begin
        e_err     = 1;
        m_aligned = 0;
      end else begin
        e_ch[m_pos]     = d;
        e_strobe[m_pos] = 1'b1;
        m_pos++;
        if (m_pos == 4) e_done = 1;
      end
    end
    e_lock = m_aligned;
  endtask

  // One clock: drive after the falling edge, return just after the rising edge.
  task automatic step(input bit r, input bit v, input bit s, input logic [W-1:0] d);
    @(negedge clk);
    #1;
    rst        = r;
    din_valid  = v;
    frame_sync = s;
    din        = d;
    model(r, v, s, d);
    @(posedge clk);
    #1;
    check_en = 1;
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("ch0_out", 32'(ch0_out), 32'(e_ch[0]));
      chk("ch1_out", 32'(ch1_out), 32'(e_ch[1]));
      chk("ch2_out", 32'(ch2_out), 32'(e_ch[2]));
      chk("ch3_out", 32'(ch3_out), 32'(e_ch[3]));
      chk("ch_strobe", 32'(ch_strobe), 32'(e_strobe));
      chk("frame_done", 32'(frame_done), 32'(e_done));
      chk("locked", 32'(locked), 32'(e_lock));
      chk("sync_err", 32'(sync_err), 32'(e_err));
    end
  end

  initial begin
    int tx_pos;
    bit s;

    // Reset then clean frame
    step(1, 0, 0, 8'h00);
    step(1, 0, 0, 8'h00);
    chk("lit_reset_locked", 32'(locked), 32'd0);
    chk("lit_reset_ch0", 32'(ch0_out), 32'd0);
    step(0, 1, 1, 8'hA1);
    chk("lit_clean_s0", 32'(ch_strobe), 32'b0001);
    chk("lit_clean_lock", 32'(locked), 32'd1);
    step(0, 1, 0, 8'hB2);
    chk("lit_clean_s1", 32'(ch_strobe), 32'b0010);
    step(0, 1, 0, 8'hC3);
    chk("lit_clean_s2", 32'(ch_strobe), 32'b0100);
    chk("lit_clean_nodone", 32'(frame_done), 32'd0);
    step(0, 1, 0, 8'hD4);
    chk("lit_clean_s3", 32'(ch_strobe), 32'b1000);
    chk("lit_clean_done", 32'(frame_done), 32'd1);
    chk("lit_clean_ch", {ch0_out, ch1_out, ch2_out, ch3_out}, 32'hA1B2C3D4);

    // Missing sync
    step(0, 1, 0, 8'h55);
    chk("lit_miss_err", 32'(sync_err), 32'd1);
    chk("lit_miss_unlock", 32'(locked), 32'd0);
    chk("lit_miss_strobe", 32'(ch_strobe), 32'd0);
    chk("lit_miss_hold", {ch0_out, ch1_out, ch2_out, ch3_out}, 32'hA1B2C3D4);
    step(0, 0, 0, 8'h00);
    chk("lit_err_pulse", 32'(sync_err), 32'd0);

    // Hunt discard
    step(0, 1, 0, 8'h11);
    chk("lit_hunt_s11", 32'(ch_strobe), 32'd0);
    step(0, 1, 0, 8'h22);
    chk("lit_hunt_s22", 32'(ch_strobe), 32'd0);
    step(0, 1, 1, 8'h33);
    chk("lit_hunt_ch0", 32'(ch0_out), 32'h33);
    chk("lit_hunt_lock", 32'(locked), 32'd1);

    // Early sync
    step(0, 1, 1, 8'h01);
    step(0, 1, 0, 8'h02);
    step(0, 1, 1, 8'h03);
    chk("lit_early_err", 32'(sync_err), 32'd1);
    chk("lit_early_ch0", 32'(ch0_out), 32'h03);
    chk("lit_early_ch1", 32'(ch1_out), 32'h02);
    chk("lit_early_nodone", 32'(frame_done), 32'd0);
    chk("lit_early_lock", 32'(locked), 32'd1);

    // Gaps
    step(1, 0, 0, 8'h00);
    step(0, 1, 1, 8'hA1);
    step(0, 0, 0, 8'hEE);
    chk("lit_gap_idle", 32'(ch_strobe), 32'd0);
    step(0, 1, 0, 8'hB2);
    step(0, 0, 1, 8'hEE);
    step(0, 1, 0, 8'hC3);
    step(0, 0, 0, 8'hEE);
    step(0, 0, 0, 8'hEE);
    step(0, 1, 0, 8'hD4);
    chk("lit_gap_done", 32'(frame_done), 32'd1);
    chk("lit_gap_ch", {ch0_out, ch1_out, ch2_out, ch3_out}, 32'hA1B2C3D4);

    // Reset mid-frame
    step(0, 1, 1, 8'h5A);
    step(0, 1, 0, 8'h6B);
    step(1, 1, 0, 8'h7C);
    chk("lit_midrst_ch", {ch0_out, ch1_out, ch2_out, ch3_out}, 32'd0);
    chk("lit_midrst_lock", 32'(locked), 32'd0);
    step(0, 1, 1, 8'h81);
    step(0, 1, 0, 8'h82);
    step(0, 1, 0, 8'h83);
    step(0, 1, 0, 8'h84);
    chk("lit_midrst_after", {ch0_out, ch1_out, ch2_out, ch3_out}, 32'h81828384);

    // Randomized traffic: mostly well-formed frames with occasional sync faults and resets
    tx_pos = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        step(1, $urandom_range(0, 1), $urandom_range(0, 1), 8'($urandom));
        tx_pos = 0;
      end else if ($urandom_range(0, 9) < 7) begin
        s = (tx_pos == 0);
        if ($urandom_range(0, 19) == 0) s = ~s;
        step(0, 1, s, 8'($urandom));
        tx_pos = (tx_pos + 1) % 4;
      end else begin
        step(0, 0, $urandom_range(0, 1), 8'($urandom));
      end
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
